memory_access_unit: RTL and testbench

//  Execute->Writeback memory stage with sub-word support, replacing the pass-through memory unit.

---
 rtl/memory_access_unit_pkg.sv | 53 +++++
 rtl/memory_access_unit_if.sv | 37 +++
 rtl/lsu_tag_fifo.sv | 52 +++++
 rtl/memory_access_unit.sv | 157 +++++++++++++++
 tb/tb_memory_access_unit.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/memory_access_unit_pkg.sv
// Shared encodings and lane helpers for the memory access unit.
// Helpers work at 64 bits; callers truncate to the bus width.
package memory_unit_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE  = 2'b00,
    SIZE_HALF  = 2'b01,
    SIZE_WORD  = 2'b10,
    SIZE_DWORD = 2'b11
  } size_e;

  function automatic logic [63:0] lane_extend(
    input logic [63:0] data,
    input logic [2:0]  lo,
    input size_e       size,
    input logic        uns
  );
    logic [63:0] s;
    logic [63:0] r;
    s = data >> {lo, 3'b000};
    r = s;
    unique case (size)
      SIZE_BYTE:
        r = uns ? {56'b0, s[7:0]}
                : {{56{s[7]}}, s[7:0]};
      SIZE_HALF:
        r = uns ? {48'b0, s[15:0]}
                : {{48{s[15]}}, s[15:0]};
      SIZE_WORD:
        r = uns ? {32'b0, s[31:0]}
                : {{32{s[31]}}, s[31:0]};
      SIZE_DWORD:
        r = s;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] byte_enable(
    input logic [2:0] lo,
    input size_e      size
  );
    logic [7:0] be;
    be = 8'h00;
    unique case (size)
      SIZE_BYTE:  be = 8'h01 << lo;
      SIZE_HALF:  be = 8'h03 << lo;
      SIZE_WORD:  be = 8'h0F << lo;
      SIZE_DWORD: be = 8'hFF;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/memory_access_unit_if.sv
// Data memory bus between the memory access unit
// (master) and the data memory (slave).
interface memory_access_unit_if #(
  parameter int ADDRESS_BITS = 20,
  parameter int DATA_WIDTH   = 32
);
  logic [ADDRESS_BITS-1:0] d_mem_address;
  logic [DATA_WIDTH-1:0]   d_mem_in_data;
  logic [DATA_WIDTH/8-1:0] d_mem_byte_en;
  logic                    d_mem_read;
  logic                    d_mem_write;
  logic                    d_mem_ready;
  logic                    d_mem_valid;
  logic [DATA_WIDTH-1:0]   d_mem_out_data;

  modport master (
    output d_mem_address,
    output d_mem_in_data,
    output d_mem_byte_en,
    output d_mem_read,
    output d_mem_write,
    input  d_mem_ready,
    input  d_mem_valid,
    input  d_mem_out_data
  );

  modport slave (
    input  d_mem_address,
    input  d_mem_in_data,
    input  d_mem_byte_en,
    input  d_mem_read,
    input  d_mem_write,
    output d_mem_ready,
    output d_mem_valid,
    output d_mem_out_data
  );
endinterface

// File: rtl/lsu_tag_fifo.sv
// In-order FIFO holding per-load context until
// the memory response comes back.
module lsu_tag_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (PW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  // pointer and occupancy bookkeeping
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // entry storage; contents are don't-care when empty
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/memory_access_unit.sv
// Execute->Writeback memory stage: sub-word stores,
// misalign detection, in-order tagged load returns.
module memory_access_unit
  import memory_unit_pkg::*;
#(
  parameter int CORE            = 0,
  parameter int DATA_WIDTH      = 32,
  parameter int ADDRESS_BITS    = 20,
  parameter int TAG_BITS        = 5,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    stall,
  input  logic                    load,
  input  logic                    store,
  input  logic [1:0]              size,
  input  logic                    unsigned_ld,
  input  logic [ADDRESS_BITS-1:0] address,
  input  logic [DATA_WIDTH-1:0]   store_data,
  input  logic [TAG_BITS-1:0]     rd_tag,
  output logic [DATA_WIDTH-1:0]   load_data,
  output logic [TAG_BITS-1:0]     load_tag,
  output logic                    load_valid,
  output logic                    busy,
  output logic                    misaligned,
  memory_access_unit_if.master    dmem,
  input  logic                    report
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int LB = $clog2(NB);
  localparam int EW = TAG_BITS + 3 + LB;
  localparam int CW = $clog2(MAX_OUTSTANDING) + 1;

  size_e                 sz;
  logic [LB-1:0]         lo;
  logic                  bad;
  logic                  rd_issue;
  logic                  wr_issue;
  logic                  pop;
  logic                  full;
  logic                  empty;
  logic [CW-1:0]         count;
  logic [EW-1:0]         push_entry;
  logic [EW-1:0]         head;
  logic [TAG_BITS-1:0]   h_tag;
  logic [1:0]            h_size;
  logic                  h_uns;
  logic [LB-1:0]         h_lo;
  logic [DATA_WIDTH-1:0] wdata;
  logic [31:0]           cycle;

  assign sz = size_e'(size);
  assign lo = address[LB-1:0];

  // alignment check against the access size
  always_comb begin
    bad = 1'b0;
    unique case (sz)
      SIZE_BYTE:  bad = 1'b0;
      SIZE_HALF:  bad = address[0];
      SIZE_WORD:  bad = |address[1:0];
      SIZE_DWORD: bad = (DATA_WIDTH != 64)
                      || (|address[2:0]);
    endcase
    misaligned = (load | store)
               & (bad | (load & store));
  end

  assign pop = dmem.d_mem_valid & ~empty;

  // a full FIFO still accepts a load when a
  // response frees the head in the same cycle
  assign rd_issue = load & ~stall & ~misaligned
                  & dmem.d_mem_ready
                  & (~full | pop);
  assign wr_issue = store & ~stall & ~misaligned
                  & dmem.d_mem_ready;
  assign busy = (load | store) & ~stall
              & ~misaligned
              & ~(rd_issue | wr_issue);

  // replicate the right-justified store data
  always_comb begin
    wdata = '0;
    for (int i = 0; i < NB; i++) begin
      unique case (sz)
        SIZE_BYTE:
          wdata[i*8 +: 8] = store_data[7:0];
        SIZE_HALF:
          wdata[i*8 +: 8] = store_data[(i%2)*8 +: 8];
        SIZE_WORD:
          wdata[i*8 +: 8] = store_data[(i%4)*8 +: 8];
        SIZE_DWORD:
          wdata[i*8 +: 8] = store_data[i*8 +: 8];
      endcase
    end
  end

  assign dmem.d_mem_address = address;
  assign dmem.d_mem_in_data = wdata;
  assign dmem.d_mem_byte_en =
    NB'(byte_enable(3'(lo), sz));
  assign dmem.d_mem_read  = rd_issue;
  assign dmem.d_mem_write = wr_issue;

  assign push_entry = {rd_tag, size, unsigned_ld, lo};
  assign {h_tag, h_size, h_uns, h_lo} = head;

  lsu_tag_fifo #(
    .WIDTH (EW),
    .DEPTH (MAX_OUTSTANDING)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (rd_issue),
    .pop   (pop),
    .din   (push_entry),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // register the aligned, extended load result
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      load_valid <= 1'b0;
      load_data  <= '0;
      load_tag   <= '0;
    end else begin
      load_valid <= pop;
      if (pop) begin
        load_data <= DATA_WIDTH'(lane_extend(
          64'(dmem.d_mem_out_data), 3'(h_lo),
          size_e'(h_size), h_uns));
        load_tag  <= h_tag;
      end
    end
  end

  // free-running cycle count for the trace
  always_ff @(posedge clock or posedge reset) begin
    if (reset) cycle <= '0;
    else       cycle <= cycle + 1'b1;
  end

`ifndef SYNTHESIS
  // per-cycle state trace
  always_ff @(posedge clock) begin
    if (report)
      $display("core%0d c=%0d a=%h ld=%b st=%b sz=%b be=%b ldat=%h busy=%b cnt=%0d",
        CORE, cycle, address, load, store, size,
        dmem.d_mem_byte_en, load_data, busy, count);
  end
`endif
endmodule

// File: tb/tb_memory_access_unit.sv
// Vector table plus hand sequences for the memory
// access unit; load results checked via scoreboard.
module tb_memory_access_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        stall;
  logic        load;
  logic        store;
  logic [1:0]  size;
  logic        unsigned_ld;
  logic [19:0] address;
  logic [31:0] store_data;
  logic [4:0]  rd_tag;
  logic [31:0] load_data;
  logic [4:0]  load_tag;
  logic        load_valid;
  logic        busy;
  logic        misaligned;
  logic        report = 1'b0;

  memory_access_unit_if #(
    .ADDRESS_BITS (20),
    .DATA_WIDTH   (32)
  ) dmem_if ();

  memory_access_unit #(
    .CORE            (0),
    .DATA_WIDTH      (32),
    .ADDRESS_BITS    (20),
    .TAG_BITS        (5),
    .MAX_OUTSTANDING (2)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .stall       (stall),
    .load        (load),
    .store       (store),
    .size        (size),
    .unsigned_ld (unsigned_ld),
    .address     (address),
    .store_data  (store_data),
    .rd_tag      (rd_tag),
    .load_data   (load_data),
    .load_tag    (load_tag),
    .load_valid  (load_valid),
    .busy        (busy),
    .misaligned  (misaligned),
    .dmem        (dmem_if),
    .report      (report)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        ld, st, stl, rdy;
    logic [1:0]  sz;
    logic        uns;
    logic [19:0] addr;
    logic [31:0] sdata, rword;
    logic [4:0]  tag;
    logic        mis, rd, wr, bsy;
    logic [3:0]  be;
    logic [31:0] wdata, ldat;
  } vec_t;

  typedef struct {
    logic [31:0] d;
    logic [4:0]  t;
  } exp_t;

  vec_t vecs [19];
  exp_t sb [$];
  int   applied = 0;
  int   miscompares = 0;

  task automatic check(input string n,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h",
               n, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic ld, st, stl, rdy,
    input logic [1:0] sz, input logic uns,
    input logic [19:0] addr,
    input logic [31:0] sdata, rword,
    input logic [4:0] tag,
    input logic mis, rd, wr, bsy,
    input logic [3:0] be,
    input logic [31:0] wdata, ldat);
    vec_t v;
    v.ld = ld; v.st = st; v.stl = stl;
    v.rdy = rdy; v.sz = sz; v.uns = uns;
    v.addr = addr; v.sdata = sdata;
    v.rword = rword; v.tag = tag;
    v.mis = mis; v.rd = rd; v.wr = wr;
    v.bsy = bsy; v.be = be;
    v.wdata = wdata; v.ldat = ldat;
    return v;
  endfunction

  task automatic idle();
    load = 0; store = 0; stall = 0;
    size = 2'b10; unsigned_ld = 0;
    address = '0; store_data = '0; rd_tag = '0;
    dmem_if.d_mem_ready = 1;
    dmem_if.d_mem_valid = 0;
    dmem_if.d_mem_out_data = '0;
  endtask

  task automatic drive_lw(input logic [19:0] a,
                          input logic [4:0] t);
    load = 1; store = 0; size = 2'b10;
    unsigned_ld = 0; address = a; rd_tag = t;
  endtask

  // scoreboard: compare each registered return
  always @(negedge clock) begin
    if (!reset && load_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_load_valid", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("load_data", load_data, e.d);
        check("load_tag", 32'(load_tag),
              32'(e.t));
      end
    end
  end

  initial begin
    vecs[0]  = mk(1,0,0,1,2'b10,0,20'h00100,0,
      32'hDEADBEEF,3, 0,1,0,0,4'hF,0,32'hDEADBEEF);
    vecs[1]  = mk(1,0,0,1,2'b00,0,20'h00103,0,
      32'h80FF0000,4, 0,1,0,0,4'h8,0,32'hFFFFFF80);
    vecs[2]  = mk(1,0,0,1,2'b00,1,20'h00103,0,
      32'h80FF0000,5, 0,1,0,0,4'h8,0,32'h00000080);
    vecs[3]  = mk(1,0,0,1,2'b01,0,20'h00102,0,
      32'h80FF0000,6, 0,1,0,0,4'hC,0,32'hFFFF80FF);
    vecs[4]  = mk(1,0,0,1,2'b01,1,20'h00100,0,
      32'h1234ABCD,7, 0,1,0,0,4'h3,0,32'h0000ABCD);
    vecs[5]  = mk(1,0,0,1,2'b00,0,20'h00101,0,
      32'h00007F00,8, 0,1,0,0,4'h2,0,32'h0000007F);
    vecs[6]  = mk(1,0,0,1,2'b00,0,20'h00102,0,
      32'h00FE0000,9, 0,1,0,0,4'h4,0,32'hFFFFFFFE);
    vecs[7]  = mk(0,1,0,1,2'b01,0,20'h00102,
      32'h1234,0,0, 0,0,1,0,4'hC,32'h12341234,0);
    vecs[8]  = mk(0,1,0,1,2'b00,0,20'h00101,
      32'hAB,0,0, 0,0,1,0,4'h2,32'hABABABAB,0);
    vecs[9]  = mk(0,1,0,1,2'b10,0,20'h00104,
      32'hCAFEF00D,0,0, 0,0,1,0,4'hF,
      32'hCAFEF00D,0);
    vecs[10] = mk(1,0,0,1,2'b01,0,20'h00101,0,0,1,
      1,0,0,0,0,0,0);
    vecs[11] = mk(1,0,0,1,2'b10,0,20'h00102,0,0,1,
      1,0,0,0,0,0,0);
    vecs[12] = mk(0,1,0,1,2'b10,0,20'h00101,1,0,0,
      1,0,0,0,0,0,0);
    vecs[13] = mk(1,0,0,1,2'b11,0,20'h00100,0,0,1,
      1,0,0,0,0,0,0);
    vecs[14] = mk(1,1,0,1,2'b10,0,20'h00100,1,0,1,
      1,0,0,0,0,0,0);
    vecs[15] = mk(1,0,1,1,2'b10,0,20'h00100,0,0,1,
      0,0,0,0,0,0,0);
    vecs[16] = mk(1,0,0,0,2'b10,0,20'h00100,0,0,1,
      0,0,0,1,0,0,0);
    vecs[17] = mk(0,1,0,0,2'b10,0,20'h00100,1,0,0,
      0,0,0,1,0,0,0);
    vecs[18] = mk(0,1,1,1,2'b00,0,20'h00100,1,0,0,
      0,0,0,0,0,0,0);

    idle();
    reset = 1;
    @(posedge clock); #1;
    check("rst_load_valid", 32'(load_valid), 0);
    check("rst_load_data", load_data, 0);
    check("rst_load_tag", 32'(load_tag), 0);
    check("rst_count",
          32'(dut.u_fifo.count), 0);
    @(posedge clock); #1;
    reset = 0;

    foreach (vecs[i]) begin
      vec_t v;
      v = vecs[i];
      @(posedge clock); #1;
      load = v.ld; store = v.st;
      stall = v.stl; size = v.sz;
      unsigned_ld = v.uns; address = v.addr;
      store_data = v.sdata; rd_tag = v.tag;
      dmem_if.d_mem_ready = v.rdy;
      dmem_if.d_mem_valid = 0;
      #3;
      check($sformatf("v%0d_mis", i),
            32'(misaligned), 32'(v.mis));
      check($sformatf("v%0d_rd", i),
            32'(dmem_if.d_mem_read), 32'(v.rd));
      check($sformatf("v%0d_wr", i),
            32'(dmem_if.d_mem_write), 32'(v.wr));
      check($sformatf("v%0d_busy", i),
            32'(busy), 32'(v.bsy));
      check($sformatf("v%0d_addr", i),
            32'(dmem_if.d_mem_address),
            32'(v.addr));
      if (v.rd || v.wr)
        check($sformatf("v%0d_be", i),
              32'(dmem_if.d_mem_byte_en),
              32'(v.be));
      if (v.wr)
        check($sformatf("v%0d_wdata", i),
              dmem_if.d_mem_in_data, v.wdata);
      if (!v.rd)
        check($sformatf("v%0d_count", i),
              32'(dut.u_fifo.count), 0);
      if (v.rd) sb.push_back('{v.ldat, v.tag});
      @(posedge clock); #1;
      idle();
      if (v.rd) begin
        dmem_if.d_mem_valid = 1;
        dmem_if.d_mem_out_data = v.rword;
        #3;
        check($sformatf("v%0d_early", i),
              32'(load_valid), 0);
      end
      @(posedge clock); #1;
      dmem_if.d_mem_valid = 0;
      #3;
      check($sformatf("v%0d_lv", i),
            32'(load_valid), 32'(v.rd));
    end

    // full FIFO: third load waits for a pop
    @(posedge clock); #1;
    drive_lw(20'h00200, 5'd10);
    #3;
    check("q_rd0", 32'(dmem_if.d_mem_read), 1);
    sb.push_back('{32'h11111111, 5'd10});
    @(posedge clock); #1;
    drive_lw(20'h00204, 5'd11);
    #3;
    check("q_rd1", 32'(dmem_if.d_mem_read), 1);
    sb.push_back('{32'h22222222, 5'd11});
    for (int k = 0; k < 2; k++) begin
      @(posedge clock); #1;
      drive_lw(20'h00208, 5'd12);
      #3;
      check("q_full_busy", 32'(busy), 1);
      check("q_full_rd",
            32'(dmem_if.d_mem_read), 0);
      check("q_full_count",
            32'(dut.u_fifo.count), 2);
    end
    @(posedge clock); #1;
    dmem_if.d_mem_valid = 1;
    dmem_if.d_mem_out_data = 32'h11111111;
    #3;
    check("q_pop_busy", 32'(busy), 0);
    check("q_pop_rd", 32'(dmem_if.d_mem_read), 1);
    sb.push_back('{32'h33333333, 5'd12});
    @(posedge clock); #1;
    load = 0;
    dmem_if.d_mem_out_data = 32'h22222222;
    #3;
    check("q_pushpop_count",
          32'(dut.u_fifo.count), 2);
    @(posedge clock); #1;
    dmem_if.d_mem_out_data = 32'h33333333;
    @(posedge clock); #1;
    dmem_if.d_mem_valid = 0;
    @(posedge clock); #1;
    check("q_drain_count",
          32'(dut.u_fifo.count), 0);
    check("q_sb_empty", sb.size(), 0);

    // reset drops in-flight loads
    @(posedge clock); #1;
    drive_lw(20'h00300, 5'd20);
    sb.push_back('{32'h0, 5'd20});
    @(posedge clock); #1;
    drive_lw(20'h00304, 5'd21);
    sb.push_back('{32'h0, 5'd21});
    @(posedge clock); #1;
    load = 0;
    #3;
    check("r_pre_count",
          32'(dut.u_fifo.count), 2);
    reset = 1;
    sb.delete();
    #1;
    check("r_count", 32'(dut.u_fifo.count), 0);
    check("r_lv", 32'(load_valid), 0);
    @(posedge clock); #1;
    reset = 0;
    dmem_if.d_mem_valid = 1;
    dmem_if.d_mem_out_data = 32'h55555555;
    @(posedge clock); #1;
    dmem_if.d_mem_valid = 0;
    #3;
    check("r_late_lv", 32'(load_valid), 0);
    check("r_late_count",
          32'(dut.u_fifo.count), 0);
    @(posedge clock); #1;
    check("final_sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             applied, miscompares);
    $finish;
  end

endmodule
